// File: rtl/vga_frame_reader.sv
// vga_frame_reader
// Scan-out engine for the image region of data memory. Reads one 8-bit
// grayscale byte per pixel clock and drives a VGA raster; the gray value is
// replicated onto R, G and B. The image window sits at the top-left of the
// visible area, and everything outside it is black.
//
// Build option: define VGA_FRAME_BORDER_EN to draw a 1-pixel white border just
// right of and just below the image window while showing. When it is left
// undefined, those pixels are black and the border logic is not built.
//
// Ports
//   clk_i           pixel clock (single clock domain)
//   rst_ni          asynchronous active-low reset
//   start_i         arms the display (pulse or level)
//   image_select_i  0: image at IMG0_BASE, 1: image at IMG1_BASE
//   mem_addr_o      memory read address (data returns one cycle later)
//   mem_rdata_i     memory read data
//   hsync_o         horizontal sync, active-low, aligned with rgb_out_o
//   vsync_o         vertical sync, active-low, aligned with rgb_out_o
//   rgb_out_o       {R,G,B} pixel
//   active_o        high while in SHOW
//   frame_done_o    one-cycle pulse together with the last image pixel
//
// States
//   IDLE  | output black, syncs running, waiting for start_i
//   ARMED | waiting for the frame boundary to begin showing
//   SHOW  | image shown; image_select_i re-latched at every frame boundary
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IMG0_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] IMG1_BASE = 16'h4000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              image_select_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [23:0]       rgb_out_o,
  output logic              active_o,
  output logic              frame_done_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS      = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] H_IMG      = HCW'(IMG_W);
  localparam logic [HCW-1:0] H_IMG_LAST = HCW'(IMG_W - 1);

  localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS      = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] V_IMG      = VCW'(IMG_H);
  localparam logic [VCW-1:0] V_IMG_LAST = VCW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  // Stage 0: raster counters and window decode
  logic [HCW-1:0]    hcnt_q, hcnt_d;
  logic [VCW-1:0]    vcnt_q, vcnt_d;
  state_t            state_q;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] base_d;
  logic              active_q;

  logic frame_end;
  logic reload;
  logic showing;
  logic visible;
  logic in_img;
  logic win0, hs0, vs0, last0;

  // Stage 1 / stage 2
  logic        win1_q, hs1_q, vs1_q, last1_q;
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, frame_done_q;

  always_comb begin
    hcnt_d = hcnt_q + HCW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  assign showing   = (state_q == S_SHOW);
  assign visible   = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
  assign in_img    = visible && (hcnt_q < H_IMG) && (vcnt_q < V_IMG);
  assign win0      = showing && in_img;
  assign hs0       = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
  assign vs0       = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
  assign last0     = showing && (hcnt_q == H_IMG_LAST) && (vcnt_q == V_IMG_LAST);

  // The selection and pointer base are taken at every boundary once armed,
  // so a mid-frame image_select_i change only lands at the next frame.
  assign reload = frame_end && (state_q != S_IDLE);
  assign sel_d  = reload ? image_select_i : sel_q;
  assign base_d = sel_d ? IMG1_BASE : IMG0_BASE;

  // The pointer advances once per in-window cycle. The window holds exactly
  // IMG_W*IMG_H pixels, so after the last one it rests until the next reload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      ptr_q    <= IMG0_BASE;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (frame_end) begin
            state_q  <= S_SHOW;
            active_q <= 1'b1;
          end
        end
        S_SHOW: begin
          state_q <= S_SHOW;
        end
        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase

      sel_q <= sel_d;
      if (reload) begin
        ptr_q <= base_d;
      end else if (win0) begin
        ptr_q <= ptr_q + ADDR_W'(1);
      end
    end
  end

`ifdef VGA_FRAME_BORDER_EN
  logic border0, border1_q;

  assign border0 = showing && visible &&
                   (((hcnt_q == H_IMG) && (vcnt_q <= V_IMG)) ||
                    ((vcnt_q == V_IMG) && (hcnt_q <= H_IMG)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) border1_q <= 1'b0;
    else         border1_q <= border0;
  end

  assign rgb_d = win1_q    ? {3{mem_rdata_i}} :
                 border1_q ? 24'hFFFFFF       : 24'h000000;
`else
  assign rgb_d = win1_q ? {3{mem_rdata_i}} : 24'h000000;
`endif

  // Sync and window flags travel alongside the memory read so that pixels
  // and syncs reach the pins together, two cycles after the counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win1_q       <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      last1_q      <= 1'b0;
      rgb_q        <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      win1_q       <= win0;
      hs1_q        <= hs0;
      vs1_q        <= vs0;
      last1_q      <= last0;
      rgb_q        <= rgb_d;
      hsync_q      <= hs1_q;
      vsync_q      <= vs1_q;
      frame_done_q <= last1_q;
    end
  end

  assign mem_addr_o   = ptr_q;
  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign rgb_out_o    = rgb_q;
  assign active_o     = active_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader with a reduced raster (56x37 total, 16x12 image)
// so that many whole frames fit in a short run.
module tb_vga_frame_reader;

  localparam int HA = 40, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int IW = 16, IH = 12;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT;
`ifdef VGA_FRAME_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        image_select;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        hsync, vsync, active, frame_done;
  logic [23:0] rgb_out;

  logic [7:0] mem [0:65535];
  bit         sel_hist [0:255];

  int n = 0;
  int show_frame = -1;
  int asserts = 0;
  int failures = 0;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(16),
    .IMG0_BASE(16'h0000), .IMG1_BASE(16'h4000)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .image_select_i(image_select),
    .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata),
    .hsync_o(hsync),
    .vsync_o(vsync),
    .rgb_out_o(rgb_out),
    .active_o(active),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  function automatic int base_of(input bit s);
    return s ? 32'h4000 : 32'h0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Reference: cycle n after reset release has raster position n mod FR.
  // Pins show the position of cycle n-2. A frame F is shown when a start was
  // seen in IDLE and F is at or after the frame computed from that start.
  always @(negedge clk) begin
    int c, f, p, h, v, off;
    logic [15:0] a;
    logic [23:0] e_rgb;
    logic [15:0] e_addr;
    logic e_hs, e_vs, e_fd, e_act, shown;
    if (!rst_n) begin
      n = 0;
      show_frame = -1;
      chk("rst_rgb", 32'(rgb_out), 32'h0);
      chk("rst_hsync", 32'(hsync), 32'h1);
      chk("rst_vsync", 32'(vsync), 32'h1);
      chk("rst_fd", 32'(frame_done), 32'h0);
      chk("rst_active", 32'(active), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
    end else begin
      c = n - 2;
      e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_fd = 1'b0;
      if (c >= 0) begin
        f = c / FR; p = c % FR; h = p % HT; v = p / HT;
        e_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
        e_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
        shown = (show_frame >= 0) && (f >= show_frame);
        if (shown && h < IW && v < IH) begin
          a = 16'(base_of(sel_hist[f % 256]) + v * IW + h);
          e_rgb = {3{mem[a]}};
        end else if (BORDER && shown && ((h == IW && v <= IH) || (v == IH && h <= IW))) begin
          e_rgb = 24'hFFFFFF;
        end
        e_fd = shown && (h == IW - 1) && (v == IH - 1);
      end
      f = n / FR; p = n % FR; h = p % HT; v = p / HT;
      e_act = (show_frame >= 0) && (f >= show_frame);
      if (e_act) begin
        off = (v < IH) ? (v * IW + ((h < IW) ? h : IW)) : IW * IH;
        e_addr = 16'(base_of(sel_hist[f % 256]) + off);
      end else begin
        e_addr = 16'h0000;
      end
      chk("rgb", 32'(rgb_out), 32'(e_rgb));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("active", 32'(active), 32'(e_act));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      // inputs seen now are sampled by the DUT at the end of this cycle
      if (show_frame < 0 && start) show_frame = (n + 1) / FR + 1;
      if (n % FR == FR - 1) sel_hist[(n / FR + 1) % 256] = image_select;
      n++;
    end
  end

  // Returns at negedge+1 of cycle k (n has just become k+1).
  task automatic at_cycle(input int k);
    int guard;
    guard = 0;
    while (n != k + 1) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 3 * FR) begin
        asserts++;
        failures++;
        $display("FAIL at_cycle_timeout: got cycle %0d required %0d", n, k + 1);
        break;
      end
    end
  endtask

  task automatic pulse_start_at(input int k);
    at_cycle(k - 1);
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, vs_low, fd_cnt, ks, s, kr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    for (int i = 0; i < IW * IH; i++) mem[16'h4000 + i] = 8'hAA;
    rst_n = 1'b0; start = 1'b0; image_select = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // idle: syncs run, image stays dark, address parked at IMG0_BASE
    at_cycle(100);
    chk("idle_addr", 32'(mem_addr), 32'h0);
    chk("idle_rgb", 32'(rgb_out), 32'h0);
    hs_low = 0; vs_low = 0;
    for (int k = FR; k < 2 * FR; k++) begin
      at_cycle(k);
      if (k < FR + HT && !hsync) hs_low++;
      if (!vsync) vs_low++;
    end
    chk("hsync_low_per_line", 32'(hs_low), 32'd8);
    chk("vsync_low_per_frame", 32'(vs_low), 32'd112);

    // start mid-frame 2 -> frame 3 shown
    ks = 2 * FR + $urandom_range(100, FR - 200);
    pulse_start_at(ks);
    s = 3 * FR;
    at_cycle(s - 1);   chk("active_before", 32'(active), 32'h0);
    at_cycle(s);       chk("active_rise", 32'(active), 32'h1);
    at_cycle(s + 2);   chk("pix_0_0", 32'(rgb_out), 32'h000000);
    at_cycle(s + 7);   chk("pix_5_0", 32'(rgb_out), 32'h050505);
    at_cycle(s + 18);  chk("pix_w_0", 32'(rgb_out), BORDER ? 32'hFFFFFF : 32'h0);
    at_cycle(s + 58);  chk("pix_0_1", 32'(rgb_out), 32'h101010);
    at_cycle(s + 11 * HT + 17);
    chk("last_pix", 32'(rgb_out), 32'hBFBFBF);
    chk("last_fd", 32'(frame_done), 32'h1);
    at_cycle(s + 12 * HT + 2);
    chk("pix_0_h", 32'(rgb_out), BORDER ? 32'hFFFFFF : 32'h0);

    // frame 4: switch to image 1 mid-frame; takes effect in frame 5 only
    s = 4 * FR;
    at_cycle(s + 99);
    @(posedge clk); #2;
    image_select = 1'b1;
    fd_cnt = 0;
    for (int k = s + 101; k <= s + FR + 100; k++) begin
      at_cycle(k);
      if (frame_done) fd_cnt++;
      if (k == s + 11 * HT + 12) chk("midframe_sel_ignored", 32'(rgb_out), 32'hBABABA);
    end
    chk("fd_once_per_frame", 32'(fd_cnt), 32'd1);
    at_cycle(5 * FR + 2 * HT + 5);
    chk("img1_pix_3_2", 32'(rgb_out), 32'hAAAAAA);

    // random select toggles and ignored start pulses over several frames
    while (n < 13 * FR) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 299) == 0) image_select = ~image_select;
      start = ($urandom_range(0, 499) == 0);
    end
    start = 1'b0;

    // asynchronous reset in the middle of the image window
    kr = 13 * FR + 5 * HT + 10;
    at_cycle(kr - 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb_out), 32'h0);
    chk("async_rst_active", 32'(active), 32'h0);
    chk("async_rst_addr", 32'(mem_addr), 32'h0);
    chk("async_rst_hsync", 32'(hsync), 32'h1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // after reset: no image until a new start, issued on the boundary cycle
    at_cycle(FR / 2);  chk("post_rst_idle", 32'(active), 32'h0);
    pulse_start_at(FR - 1);
    at_cycle(FR);      chk("boundary_start_not_now", 32'(active), 32'h0);
    at_cycle(2 * FR - 1); chk("boundary_start_armed", 32'(active), 32'h0);
    at_cycle(2 * FR);  chk("boundary_start_show", 32'(active), 32'h1);
    at_cycle(2 * FR + 7);
    chk("post_rst_pix_5_0", 32'(rgb_out), image_select ? 32'hAAAAAA : 32'h050505);
    at_cycle(3 * FR + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
